// File: rtl/dual_port_sync_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_sync_ram_be
//
// Simple-dual-port synchronous RAM (one write port, one read port, one clock)
// with per-byte write enables, write-first collision forwarding, a selectable
// read latency of 1 or 2 cycles with a read-valid strobe, and a hardware clear
// sequencer that zeroes the whole array one word per cycle.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     asynchronous, active-low reset (control state only, not the array)
//   w_en      write request
//   w_addr    write address (addresses >= LENGTH are dropped)
//   w_data    write data
//   w_be      byte enables, bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   r_en      read request
//   r_addr    read address (addresses >= LENGTH read as zero)
//   r_data    read data, held between results
//   r_valid   one-cycle strobe per accepted read
//   clr       start a full-array clear (ignored while one is running)
//   busy      clear in progress; w_en / r_en are ignored
//   clr_done  one-cycle pulse after the last clear write
// -----------------------------------------------------------------------------
module dual_port_sync_ram_be #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int LENGTH       = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  localparam int NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [NUM_BYTES-1:0]  w_be,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clr_done
);

  // Address comparisons are done one bit wider so LENGTH == 2^ADDR_WIDTH fits.
  localparam logic [ADDR_WIDTH:0] LEN_EXT  = (ADDR_WIDTH+1)'(LENGTH);
  localparam logic [ADDR_WIDTH:0] LAST_EXT = (ADDR_WIDTH+1)'(LENGTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [LENGTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_done_q, clr_done_d;

  logic                  w_in_range, r_in_range;
  logic                  user_wr, rd_acc, collide;
  logic [NUM_BYTES-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] old_word, rd_word;

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q, s1_valid_d;

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  assign w_in_range = ({1'b0, w_addr} < LEN_EXT);
  assign r_in_range = ({1'b0, r_addr} < LEN_EXT);
  assign user_wr    = w_en & ~busy & w_in_range;
  assign rd_acc     = r_en & ~busy;
  assign collide    = user_wr & (w_addr == r_addr);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if ({1'b0, cnt_q} == LAST_EXT) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port: the clear sequencer owns the port while busy, so user writes
  // and clear writes never compete for the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = '0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    if (busy) begin
      mem_we    = '1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (user_wr) begin
      mem_we = w_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mem_we[i]) begin
        mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: write-first forwarding per lane on an address collision, so the
  // enabled lanes return the new data and the rest return the stored word.
  // ---------------------------------------------------------------------------
  assign old_word = r_in_range ? mem[r_addr] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_fwd
      assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
        (collide & w_be[gi]) ? w_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
                             : old_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  // First output stage: loads only on an accepted read, otherwise holds.
  always_comb begin
    s1_valid_d = rd_acc;
    s1_data_d  = rd_acc ? rd_word : s1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
      logic                  s2_valid_q, s2_valid_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign r_data  = s2_data_q;
      assign r_valid = s2_valid_q;
    end else begin : g_lat1
      assign r_data  = s1_data_q;
      assign r_valid = s1_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_sync_ram_be.sv
// -----------------------------------------------------------------------------
// tb_dual_port_sync_ram_be
//
// Two instances share one stimulus stream:
//   dut_a : LENGTH=256, READ_LATENCY=1
//   dut_b : LENGTH=200, READ_LATENCY=2
// A behavioural model (word arrays, a queue of pending read results, and clear
// timing derived from the cycle the clear was accepted) predicts every output
// after every clock edge.
// -----------------------------------------------------------------------------
module tb_dual_port_sync_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en, r_en, clr;
  logic [7:0]  w_addr, r_addr;
  logic [31:0] w_data;
  logic [3:0]  w_be;

  logic [31:0] r_data_a, r_data_b;
  logic        r_valid_a, r_valid_b;
  logic        busy_a, busy_b;
  logic        clr_done_a, clr_done_b;

  always #5 clk = ~clk;

  dual_port_sync_ram_be #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8), .LENGTH(256), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data_a), .r_valid(r_valid_a),
    .clr(clr), .busy(busy_a), .clr_done(clr_done_a)
  );

  dual_port_sync_ram_be #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8), .LENGTH(200), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data_b), .r_valid(r_valid_b),
    .clr(clr), .busy(busy_b), .clr_done(clr_done_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [31:0] mem_m  [2][256];
  int          len_m  [2] = '{256, 200};
  int          lat_m  [2] = '{1, 2};
  int          clr_s  [2];          // edge number that accepted the clear, -1 none
  logic [31:0] last_d [2];          // value r_data must be holding
  logic [63:0] pend_a [$];          // {due edge, data}
  logic [63:0] pend_b [$];
  int          cyc;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Apply one clock edge's worth of the rules to instance x.
  task automatic model_edge(input int x);
    int          s, l;
    logic [31:0] word;
    s = clr_s[x];
    l = len_m[x];
    if (s >= 0 && cyc > s && cyc <= s + l) begin
      // k-th edge after acceptance zeroes word k-1
      mem_m[x][cyc - s - 1] = 32'h0;
    end else begin
      if (r_en) begin
        word = (int'(r_addr) < l) ? mem_m[x][r_addr] : 32'h0;
        if (w_en && w_addr == r_addr && int'(w_addr) < l) begin
          for (int b = 0; b < 4; b++)
            if (w_be[b]) word[b*8 +: 8] = w_data[b*8 +: 8];
        end
        if (x == 0) pend_a.push_back({32'(cyc + lat_m[x] - 1), word});
        else        pend_b.push_back({32'(cyc + lat_m[x] - 1), word});
      end
      if (w_en && int'(w_addr) < l) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) mem_m[x][w_addr][b*8 +: 8] = w_data[b*8 +: 8];
      end
      if (clr) clr_s[x] = cyc;
    end
  endtask

  task automatic check_outputs();
    for (int x = 0; x < 2; x++) begin
      logic [63:0] head;
      logic        ev;
      logic        eb, ed;
      int          s;
      string       n;
      ev   = 1'b0;
      head = '0;
      if (x == 0) begin
        if (pend_a.size() > 0 && int'(pend_a[0][63:32]) == cyc) begin
          head = pend_a.pop_front();
          ev   = 1'b1;
        end
      end else begin
        if (pend_b.size() > 0 && int'(pend_b[0][63:32]) == cyc) begin
          head = pend_b.pop_front();
          ev   = 1'b1;
        end
      end
      if (ev) last_d[x] = head[31:0];
      s  = clr_s[x];
      eb = (s >= 0 && cyc >= s && cyc <= s + len_m[x] - 1);
      ed = (s >= 0 && cyc == s + len_m[x]);
      n  = (x == 0) ? "a" : "b";
      check_eq({n, "_r_valid"},  32'(x == 0 ? r_valid_a  : r_valid_b),  32'(ev));
      check_eq({n, "_r_data"},   (x == 0 ? r_data_a : r_data_b),        last_d[x]);
      check_eq({n, "_busy"},     32'(x == 0 ? busy_a     : busy_b),     32'(eb));
      check_eq({n, "_clr_done"}, 32'(x == 0 ? clr_done_a : clr_done_b), 32'(ed));
    end
  endtask

  // Drive one cycle of inputs, take the edge, update the model, then compare.
  task automatic step(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [7:0] ra,
                      input logic c);
    w_en = we; w_addr = wa; w_data = wd; w_be = be;
    r_en = re; r_addr = ra; clr = c;
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, a, d, be, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, a, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_busy"},    32'(busy_a),     32'h0);
    check_eq({tag, "_a_r_valid"}, 32'(r_valid_a),  32'h0);
    check_eq({tag, "_a_r_data"},  r_data_a,        32'h0);
    check_eq({tag, "_a_done"},    32'(clr_done_a), 32'h0);
    check_eq({tag, "_b_busy"},    32'(busy_b),     32'h0);
    check_eq({tag, "_b_r_valid"}, 32'(r_valid_b),  32'h0);
    check_eq({tag, "_b_r_data"},  r_data_b,        32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop without an edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    pend_a.delete();
    pend_b.delete();
    clr_s  = '{-1, -1};
    last_d = '{32'h0, 32'h0};
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt;
    logic [7:0] a1, a2;

    rst_n = 1'b0;
    w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
    r_en = 1'b0; r_addr = '0; clr = 1'b0;
    cyc = 0;
    clr_s  = '{-1, -1};
    last_d = '{32'h0, 32'h0};
    for (int x = 0; x < 2; x++)
      for (int i = 0; i < 256; i++) mem_m[x][i] = 32'h0;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Bring the array to a known all-zero state.
    step(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0, 1'b1);
    for (int i = 0; i < 260; i++) idle();

    // Byte enables
    wr(8'h10, 32'hAABBCCDD, 4'b1111);
    wr(8'h10, 32'h11223344, 4'b0101);
    rd(8'h10);
    check_eq("be_a_data", r_data_a, 32'hAA22CC44);
    check_eq("be_a_valid", 32'(r_valid_a), 32'h1);
    idle();
    check_eq("be_a_valid_drop", 32'(r_valid_a), 32'h0);
    check_eq("be_b_data", r_data_b, 32'hAA22CC44);

    // Write-first collision
    wr(8'h20, 32'h00000000, 4'b1111);
    step(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0011, 1'b1, 8'h20, 1'b0);
    check_eq("coll_a_data", r_data_a, 32'h0000FFFF);
    rd(8'h20);
    check_eq("coll_a_reread", r_data_a, 32'h0000FFFF);
    check_eq("coll_b_data", r_data_b, 32'h0000FFFF);
    idle();

    // Latency-2 streaming on dut_b
    wr(8'h01, 32'h1, 4'hF);
    wr(8'h02, 32'h2, 4'hF);
    wr(8'h03, 32'h3, 4'hF);
    rd(8'h01);
    check_eq("lat2_not_yet", 32'(r_valid_b), 32'h0);
    rd(8'h02);
    check_eq("lat2_d1", r_data_b, 32'h1);
    rd(8'h03);
    check_eq("lat2_d2", r_data_b, 32'h2);
    idle();
    check_eq("lat2_d3", r_data_b, 32'h3);
    idle();
    check_eq("lat2_end", 32'(r_valid_b), 32'h0);

    // Full clear with user traffic mid-clear
    wr(8'h00, 32'h5A5A5A5A, 4'hF);
    wr(8'hFF, 32'h5A5A5A5A, 4'hF);
    step(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0, 1'b1);
    busy_cnt = busy_a ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 270; i++) begin
      if (i >= 50 && i < 60)
        step(1'b1, 8'($urandom_range(0, 255)), $urandom, 4'hF, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      else
        idle();
      if (busy_a) busy_cnt++;
      if (clr_done_a) done_cnt++;
    end
    check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd256);
    check_eq("clr_done_pulses", 32'(done_cnt), 32'd1);
    rd(8'h00);
    check_eq("clr_a_addr00", r_data_a, 32'h0);
    rd(8'hFF);
    check_eq("clr_a_addrFF", r_data_a, 32'h0);
    idle();

    // Reset in the middle of a clear
    wr(8'h00, 32'h5A5A5A5A, 4'hF);
    wr(8'hFF, 32'h5A5A5A5A, 4'hF);
    step(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0, 1'b1);
    for (int i = 0; i < 99; i++) idle();
    async_reset();
    idle();
    rd(8'h00);
    check_eq("rstclr_a_addr00", r_data_a, 32'h0);
    rd(8'hFF);
    check_eq("rstclr_a_addrFF", r_data_a, 32'h5A5A5A5A);
    idle();

    // Out-of-range handling on dut_b (LENGTH=200)
    wr(8'hF0, 32'hDEADBEEF, 4'hF);
    rd(8'hF0);
    check_eq("oor_a_data", r_data_a, 32'hDEADBEEF);
    idle();
    check_eq("oor_b_valid", 32'(r_valid_b), 32'h1);
    check_eq("oor_b_data", r_data_b, 32'h0);
    wr(8'hC7, 32'h13579BDF, 4'hF);
    rd(8'hC7);
    idle();
    check_eq("c7_b_data", r_data_b, 32'h13579BDF);

    // Randomised traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 8'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), a1, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), a2, 1'($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_port_sync_ram_be.md
Name: dual_port_sync_ram_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock.
- Adds features the single-port RAM lacks:
  - per-byte write enables;
  - write-first collision forwarding;
  - selectable read latency (1 or 2) with a read-valid strobe;
  - a hardware clear sequencer that zeroes the whole array.
- Sits between CPU/datapath logic and storage as the general-purpose scratchpad/register-file memory.

Parameters:
- ADDR_WIDTH, 8, address bits.
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- LENGTH, 1<<ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read request edge to r_valid; legal values 1 or 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- w_en  in  1  write request.
- w_addr  in  ADDR_WIDTH  write address.
- w_data  in  DATA_WIDTH  write data.
- w_be  in  NUM_BYTES  byte enables; bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
- r_en  in  1  read request.
- r_addr  in  ADDR_WIDTH  read address.
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  one-cycle strobe: r_data holds the result of a request.
- clr  in  1  start a full-array clear.
- busy  out  1  clear in progress; user ports ignored.
- clr_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - r_data=0, r_valid=0, busy=0, clr_done=0.
  - FSM goes to IDLE, clear counter=0, latency pipeline flushed.
  - Array contents are not reset.
- Write: at a rising edge with w_en=1, busy=0, w_addr<LENGTH:
  - each lane i with w_be[i]=1 is updated from w_data; other lanes are unchanged.
  - w_be=0 is a no-op.
  - w_addr ≥ LENGTH: write is dropped.
- Read: at a rising edge with r_en=1, busy=0, the request is accepted.
  - Word is the array content at r_addr; r_addr ≥ LENGTH reads 0.
  - Collision (same edge, w_en=1, w_addr==r_addr): enabled lanes return the new w_data, disabled lanes return the old contents (write-first).
- Latency:
  - READ_LATENCY=1: r_data/r_valid update at the edge that accepts the request; visible in the following cycle.
  - READ_LATENCY=2: one extra output register stage; r_valid follows the request by two edges.
  - Back-to-back reads are sustained at one per cycle in both modes.
- r_valid pulses one cycle per accepted read.
- r_data holds its last value when no result is delivered; it is never cleared except by reset.
- Clear FSM, IDLE→CLEAR:
  - Transition: edge with clr=1 in IDLE; busy rises on that edge.
  - In CLEAR: each edge writes 0 to address cnt, then cnt++.
  - After address LENGTH-1 is written: back to IDLE, busy=0, clr_done=1 for one cycle.
  - Clear takes exactly LENGTH cycles of busy.
  - clr asserted during CLEAR is ignored (no restart).
- While busy=1, w_en and r_en are ignored: no write, no r_valid.
  - Reads accepted before clr was sampled still complete on schedule; their data reflects pre-clear contents.
- Clear issued in the same edge as w_en/r_en in IDLE: the user write and read are performed, then the clear starts.
- Reset mid-clear aborts immediately. Array is left partially cleared; no clr_done pulse.

Test Plan:
- Byte enables, read-modify:
  - Write addr 0x10 data 0xAABBCCDD be=1111, then addr 0x10 data 0x11223344 be=0101.
  - Read 0x10 → r_data=0xAA22CC44, r_valid high exactly one cycle, 1 cycle after request.
- Collision:
  - Preload 0x20=0x00000000.
  - Same edge: w_en addr 0x20 data 0xFFFFFFFF be=0011; r_en addr 0x20 → r_data=0x0000FFFF.
  - Next read of 0x20 → 0x0000FFFF.
- Latency 2 streaming:
  - READ_LATENCY=2; reads of addrs 1,2,3 on consecutive edges (preloaded 0x1,0x2,0x3).
  - → r_valid high 3 consecutive cycles starting 2 edges after first request, data 0x1,0x2,0x3 in order.
- Clear sequence:
  - LENGTH=256; write 0x5A5A5A5A to 0x00 and 0xFF; pulse clr.
  - busy high exactly 256 cycles; clr_done single pulse on drop.
  - w_en/r_en issued mid-clear → no r_valid, no write.
  - Reads of 0x00/0xFF afterward → 0.
- Reset mid-clear:
  - Pulse clr; assert rst_n=0 at cycle 100 asynchronously (mid-cycle).
  - → busy, r_valid, r_data immediately 0; no clr_done.
  - Addr 0x00 reads 0; addr 0xFF keeps prior 0x5A5A5A5A.
- Out of range:
  - LENGTH=200, ADDR_WIDTH=8; write 0xDEADBEEF to 0xF0, then read 0xF0 → 0.
  - Addr 0xC7 round-trips normally.
